// File: rtl/mac_rx_pkg.sv
// Shared types and constants for the MII/GMII receive framer.
package mac_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME,
    ST_COMMIT,
    ST_DROP
  } state_t;

  localparam int unsigned ALIGN_ERR_BIT = 12;
  localparam int unsigned TRUNC_BIT     = 13;
  localparam int unsigned LEN_ERR_BIT   = 14;
  localparam int unsigned CRC_ERR_BIT   = 15;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [3:0] SFD_NIB  = 4'hD;

  localparam logic [31:0] CRC_RESIDUE_DEFAULT = 32'hC704DD7B;

  function automatic logic is_mii(input logic [1:0] spd);
    return (spd == SPD_10) || (spd == SPD_100);
  endfunction

endpackage

// File: rtl/crc32_8023.sv
// IEEE 802.3 CRC-32, one byte per cycle, LSB-first; register exposed bit-reversed.
module crc32_8023 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_init,
  input  logic        calc,
  input  logic        d_valid,
  input  logic [7:0]  data,
  output logic [31:0] crc_reg
);

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;

  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  always_comb begin
    w_crc_next = r_crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_crc_next[0] ^ data[i]) w_crc_next = (w_crc_next >> 1) ^ POLY_REFL;
      else                         w_crc_next = w_crc_next >> 1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                r_crc <= '1;
    else if (load_init)       r_crc <= '1;
    else if (calc && d_valid) r_crc <= w_crc_next;
  end

  // Bit-reversed view so a good frame leaves the MSB-first residue 0xC704DD7B.
  always_comb begin
    crc_reg = '0;
    for (int unsigned i = 0; i < 32; i++) crc_reg[i] = r_crc[31-i];
  end

endmodule

// File: rtl/mac_rx_framer.sv
// MII/GMII receive framer: strips preamble/SFD, assembles nibbles, checks
// CRC/length/alignment, writes payload bytes and commits one descriptor per frame.
module mac_rx_framer
  import mac_rx_pkg::*;
#(
  parameter int unsigned LEN_W       = 12,
  parameter int unsigned MIN_LEN     = 64,
  parameter int unsigned MAX_LEN     = 1518,
  parameter bit          DROP_BAD    = 1'b0,
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] CRC_RESIDUE = CRC_RESIDUE_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx_dv,
  input  logic [7:0]       rx_d,
  input  logic [1:0]       speed,
  input  logic [LEN_W-1:0] data_space,
  input  logic             desc_full,
  output logic             data_wr,
  output logic [7:0]       data_dout,
  output logic             data_rollback,
  output logic             desc_wr,
  output logic [15:0]      desc_dout,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] CNT_SAT   = '1;

  logic             r_dv_q;
  logic             r_dv_qp;
  logic [7:0]       r_d_q;
  logic [1:0]       r_speed;
  state_t           r_state;
  state_t           w_state_next;
  logic [LEN_W-1:0] r_byte_cnt;
  logic             r_nib_phase;
  logic [3:0]       r_nib_lo;
  logic             r_trunc;

  logic             w_sof;
  logic             w_mii;
  logic             w_sfd_mii;
  logic             w_sfd;
  logic             w_space_ok;
  logic             w_start;
  logic             w_in_frame;
  logic             w_byte_vld;
  logic [7:0]       w_byte;
  logic             w_wr_ok;
  logic [31:0]      w_crc;
  logic             w_len_err;
  logic             w_crc_err;
  logic             w_align_err;
  logic             w_any_err;
  logic             w_desc_wr;
  logic             w_rollback;
  logic             w_frame_inc;
  logic             w_drop_inc;
  logic [15:0]      w_desc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dv_q  <= 1'b0;
      r_dv_qp <= 1'b0;
      r_d_q   <= '0;
      r_speed <= '0;
    end else begin
      r_dv_q  <= rx_dv;
      r_dv_qp <= r_dv_q;
      r_d_q   <= rx_d;
      if (w_sof) r_speed <= speed;
    end
  end

  assign w_sof      = r_dv_q & ~r_dv_qp;
  assign w_mii      = is_mii(r_speed);
  // The SFD can arrive on the SOF cycle, before r_speed has latched.
  assign w_sfd_mii  = w_sof ? is_mii(speed) : w_mii;
  assign w_sfd      = w_sfd_mii ? (r_d_q[3:0] == SFD_NIB) : (r_d_q == SFD_BYTE);
  assign w_space_ok = (data_space >= MAX_LEN_C) && !desc_full;
  assign w_start    = (w_state_next == ST_FRAME) && (r_state != ST_FRAME);
  assign w_in_frame = (r_state == ST_FRAME) && r_dv_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sof) begin
          if (!w_space_ok) w_state_next = ST_DROP;
          else if (w_sfd)  w_state_next = ST_FRAME;
          else             w_state_next = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (!r_dv_q)    w_state_next = ST_IDLE;
        else if (w_sfd) w_state_next = ST_FRAME;
      end
      ST_FRAME:  if (!r_dv_q) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = w_sof ? ST_DROP : ST_IDLE;
      ST_DROP:   if (!r_dv_q) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // MII: a byte completes on the second nibble, low nibble first.
  always_comb begin
    w_byte_vld = 1'b0;
    w_byte     = r_d_q;
    if (w_in_frame) begin
      if (w_mii) begin
        w_byte_vld = r_nib_phase;
        w_byte     = {r_d_q[3:0], r_nib_lo};
      end else begin
        w_byte_vld = 1'b1;
      end
    end
  end

  assign w_wr_ok = r_byte_cnt < MAX_LEN_C;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_cnt  <= '0;
      r_nib_phase <= 1'b0;
      r_nib_lo    <= '0;
      r_trunc     <= 1'b0;
      data_wr     <= 1'b0;
      data_dout   <= '0;
    end else begin
      data_wr <= w_byte_vld && w_wr_ok;
      if (w_byte_vld && w_wr_ok) data_dout <= w_byte;
      if (w_start) begin
        r_byte_cnt  <= '0;
        r_nib_phase <= 1'b0;
        r_trunc     <= 1'b0;
      end else if (w_in_frame) begin
        if (w_mii) begin
          r_nib_phase <= ~r_nib_phase;
          if (!r_nib_phase) r_nib_lo <= r_d_q[3:0];
        end
        if (w_byte_vld) begin
          if (r_byte_cnt != CNT_SAT) r_byte_cnt <= r_byte_cnt + 1'b1;
          if (!w_wr_ok)              r_trunc    <= 1'b1;
        end
      end
    end
  end

  crc32_8023 u_crc (
    .clk       (clk),
    .rstn      (rstn),
    .load_init (w_start),
    .calc      (w_in_frame),
    .d_valid   (w_byte_vld),
    .data      (w_byte),
    .crc_reg   (w_crc)
  );

  assign w_len_err   = (r_byte_cnt < MIN_LEN_C) || (r_byte_cnt > MAX_LEN_C);
  assign w_crc_err   = (w_crc != CRC_RESIDUE);
  assign w_align_err = w_mii && r_nib_phase;
  assign w_any_err   = w_len_err || w_crc_err || w_align_err || r_trunc;

  always_comb begin
    w_desc_wr   = 1'b0;
    w_rollback  = 1'b0;
    w_frame_inc = 1'b0;
    w_drop_inc  = 1'b0;
    w_desc      = '0;
    w_desc[LEN_W-1:0]    = r_byte_cnt;
    w_desc[ALIGN_ERR_BIT] = w_align_err;
    w_desc[TRUNC_BIT]     = r_trunc;
    w_desc[LEN_ERR_BIT]   = w_len_err;
    w_desc[CRC_ERR_BIT]   = w_crc_err;
    unique case (r_state)
      ST_COMMIT: begin
        if (DROP_BAD && w_any_err) begin
          w_rollback = 1'b1;
          w_drop_inc = 1'b1;
        end else begin
          w_desc_wr   = 1'b1;
          w_frame_inc = 1'b1;
        end
      end
      ST_DROP: w_drop_inc = !r_dv_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      desc_wr       <= 1'b0;
      data_rollback <= 1'b0;
      desc_dout     <= '0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      desc_wr       <= w_desc_wr;
      data_rollback <= w_rollback;
      if (w_desc_wr)   desc_dout <= w_desc;
      if (w_frame_inc) frame_cnt <= frame_cnt + 1'b1;
      if (w_drop_inc)  drop_cnt  <= drop_cnt + 1'b1;
    end
  end

endmodule
